pc_gen_ras: RTL
===============

// Module: pc_gen_ras
// PURPOSE
//   Parametrised fetch-stage program counter with stall hold, back-end redirect and a
//   circular return-address stack (RAS) for call/return prediction. Sits at the head
//   of the advanced pipeline; drives the instruction-memory address and feeds IF/ID.
//   Successor to the fixed 32-bit PC: adds reset vector, increment, redirect, RAS.
// PARAMETERS
//   WIDTH      32  PC / address width in bits
//   RESET_PC   0   value loaded into pc_o on reset (WIDTH bits)
//   INC        4   sequential increment (bytes per instruction)
//   RAS_DEPTH  8   RAS entries; power of two, >= 2; CW = $clog2(RAS_DEPTH+1)
// PORTS
//   clk_i           in   1      clock, rising edge
//   rst_i           in   1      reset, asynchronous, active-high
//   pc_write_i      in   1      1 = PC may advance; 0 = hold (load-use stall)
//   redirect_i      in   1      back-end redirect (branch/jump resolved, mispredict)
//   redirect_pc_i   in   WIDTH  redirect target
//   call_i          in   1      fetched instr predicted call: push PC+INC, go to target
//   call_target_i   in   WIDTH  call target
//   ret_i           in   1      fetched instr predicted return: pop, go to popped addr
//   pc_o            out  WIDTH  current fetch PC (registered)
//   pc_next_o       out  WIDTH  combinational next PC (value loaded at next edge)
//   ras_top_o       out  WIDTH  current RAS top entry (0 when empty)
//   ras_count_o     out  CW     valid RAS entries, 0..RAS_DEPTH
//   ras_empty_o     out  1      ras_count_o == 0
//   ret_miss_o      out  1      registered 1-cycle pulse: ret_i accepted while RAS empty
// BEHAVIOUR
//   Reset (async, any time, incl. mid-operation): pc_o=RESET_PC, ras_count_o=0,
//     RAS pointer=0, all RAS entries=0, ret_miss_o=0; ras_top_o=0, ras_empty_o=1.
//   Next-PC priority per cycle, highest first:
//     1 redirect_i        : pc_next=redirect_pc_i; ignores pc_write_i; RAS unchanged
//                           (call_i/ret_i ignored that cycle).
//     2 !pc_write_i       : pc_next=pc_o; RAS unchanged; call_i/ret_i ignored.
//     3 call_i & ret_i    : pc_next=call_target_i; top entry overwritten with pc_o+INC;
//                           count and pointer unchanged (pop+push). If empty: acts as
//                           plain call (push).
//     4 ret_i             : RAS non-empty: pc_next=top, pop (count-1, ptr-1).
//                           RAS empty: pc_next=pc_o+INC, no pop, ret_miss_o=1 next cycle.
//     5 call_i            : pc_next=call_target_i; push pc_o+INC (ptr+1 mod RAS_DEPTH).
//                           Full: overwrite oldest entry (circular), count stays RAS_DEPTH.
//     6 otherwise         : pc_next=pc_o+INC.
//   pc_o <= pc_next_o on every rising edge (when held, pc_next_o == pc_o).
//   Arithmetic: PC+INC is modulo 2^WIDTH (wraps all-ones region to low addresses).
//   Pointer arithmetic modulo RAS_DEPTH; underflow of pointer never occurs (guarded).
//   Latency: inputs sampled at edge N -> pc_o updated at edge N; RAS state and
//     ras_top_o/ras_count_o reflect push/pop after the same edge.
//   ret_miss_o high exactly one cycle after the qualifying edge, else 0.
//   No X on outputs after reset regardless of input X on ignored data ports.
// TESTING
//   T1 reset: assert rst_i mid-cycle with pc_o=0x40 -> pc_o=RESET_PC immediately,
//      ras_count_o=0, ras_empty_o=1 without waiting for a clock edge.
//   T2 sequential+stall: from 0x0, 3 cycles pc_write_i=1 then 2 cycles 0 -> pc_o
//      0x4,0x8,0xC,0xC,0xC; redirect_i=1 to 0x100 while pc_write_i=0 -> pc_o=0x100.
//   T3 call/return: pc_o=0x10, call_i to 0x200 -> pc_o=0x200, ras_top_o=0x14, count=1;
//      then ret_i -> pc_o=0x14, count=0, ras_empty_o=1.
//   T4 overflow: 9 calls from PCs 0x0,0x100,...,0x800 (DEPTH=8) -> count=8; 8 rets
//      return 0x804,0x704,...,0x104 (0x4 lost); 9th ret -> pc+4, ret_miss_o pulse.
//   T5 simultaneous: count=2 top=0x54, pc_o=0x80, call_i&ret_i target 0x300 ->
//      pc_o=0x300, ras_top_o=0x84, count=2; redirect_i with call_i -> RAS unchanged.
//   T6 wrap: RESET_PC=0xFFFFFFFC, one advance -> pc_o=0x00000000.

Source files
------------

// File: rtl/pc_gen_ras.sv
`default_nettype none
// ============================================================================
// Module   : pc_gen_ras
// Purpose  : Fetch-stage program counter with stall hold, back-end redirect
//            and a circular return-address stack for call/return prediction.
// Revision : 1.0
// ============================================================================
module pc_gen_ras #(
  parameter int               WIDTH     = 32,
  parameter logic [WIDTH-1:0] RESET_PC  = '0,
  parameter int               INC       = 4,
  parameter int               RAS_DEPTH = 8,
  localparam int              CW        = $clog2(RAS_DEPTH + 1)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             pc_write_i,
  input  logic             redirect_i,
  input  logic [WIDTH-1:0] redirect_pc_i,
  input  logic             call_i,
  input  logic [WIDTH-1:0] call_target_i,
  input  logic             ret_i,
  output logic [WIDTH-1:0] pc_o,
  output logic [WIDTH-1:0] pc_next_o,
  output logic [WIDTH-1:0] ras_top_o,
  output logic [CW-1:0]    ras_count_o,
  output logic             ras_empty_o,
  output logic             ret_miss_o
);

  localparam int               PW    = $clog2(RAS_DEPTH);
  localparam logic [WIDTH-1:0] INC_W = WIDTH'(INC);
  localparam logic [CW-1:0]    FULL  = CW'(RAS_DEPTH);

  // ptr addresses the next free slot; the top entry lives at ptr-1.
  logic [WIDTH-1:0] ras [RAS_DEPTH];
  logic [PW-1:0]    ptr;
  logic [PW-1:0]    top_idx;
  logic [WIDTH-1:0] seq_pc;
  logic             do_push;
  logic             do_pop;
  logic             do_replace;
  logic             miss;

  assign top_idx     = ptr - PW'(1);
  assign seq_pc      = pc_o + INC_W;
  assign ras_empty_o = (ras_count_o == '0);
  // Stale entries remain in the array after pops, so mask the top when empty.
  assign ras_top_o   = ras_empty_o ? '0 : ras[top_idx];

  // Next-PC selection and RAS action decode, in priority order.
  always_comb begin
    pc_next_o  = seq_pc;
    do_push    = 1'b0;
    do_pop     = 1'b0;
    do_replace = 1'b0;
    miss       = 1'b0;
    if (redirect_i) begin
      pc_next_o = redirect_pc_i;
    end else if (!pc_write_i) begin
      pc_next_o = pc_o;
    end else if (call_i && ret_i) begin
      // Pop followed by push collapses to overwriting the top entry.
      pc_next_o = call_target_i;
      if (ras_empty_o) do_push = 1'b1;
      else             do_replace = 1'b1;
    end else if (ret_i) begin
      if (!ras_empty_o) begin
        pc_next_o = ras[top_idx];
        do_pop    = 1'b1;
      end else begin
        miss = 1'b1;
      end
    end else if (call_i) begin
      pc_next_o = call_target_i;
      do_push   = 1'b1;
    end
  end

  // PC, RAS storage, pointer/count and miss-pulse registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pc_o        <= RESET_PC;
      ptr         <= '0;
      ras_count_o <= '0;
      ret_miss_o  <= 1'b0;
      for (int i = 0; i < RAS_DEPTH; i++) ras[i] <= '0;
    end else begin
      pc_o       <= pc_next_o;
      ret_miss_o <= miss;
      if (do_push) begin
        // When full, ptr already addresses the oldest entry, which is overwritten.
        ras[ptr] <= seq_pc;
        ptr      <= ptr + PW'(1);
        if (ras_count_o != FULL) ras_count_o <= ras_count_o + CW'(1);
      end
      if (do_replace) ras[top_idx] <= seq_pc;
      if (do_pop) begin
        ptr         <= ptr - PW'(1);
        ras_count_o <= ras_count_o - CW'(1);
      end
    end
  end

endmodule
`default_nettype wire
